div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle iterative 32-bit divider for the execute stage, serving MIPS DIV/DIVU and producing the HI/LO pair. It takes operands from the execute-stage datapath and returns the remainder and quotient to the HI/LO write path. While a divide is in flight it drives a stall request into the pipeline hazard logic, which holds fetch, decode and execute. It cancels on pipeline flush, e.g. an exception in memory stage.

## Interface
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse per divide instruction; ignored unless state is IDLE
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- a  in  WIDTH  dividend; sampled with start
- b  in  WIDTH  divisor; sampled with start
- annul  in  1  cancel any in-flight divide (driven by pipeline flush)
- div_stall  out  1  stall request to hazard logic
- ready  out  1  one-cycle pulse: hi/lo valid for the completed divide
- hi  out  WIDTH  remainder, registered
- lo  out  WIDTH  quotient, registered

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if start and not annul, latch signed_div, operand magnitudes (|a|, |b| when signed, raw when unsigned), quotient sign (a[MSB]^b[MSB]) and remainder sign (a[MSB]), all gated by signed_div. Clear the partial remainder (WIDTH+1 bits). Clear the counter. Go to BUSY.
- BUSY: restoring step per cycle. r = {r, next dividend MSB}; if r >= divisor then r -= divisor and the quotient bit is 1, else 0. Shift the dividend/quotient register left. The counter increments 0..WIDTH-1; on the step with counter = WIDTH-1, go to DONE.
- DONE: write lo = quotient (negated if the quotient sign is set), hi = remainder (negated if the remainder sign is set). Pulse ready. Return to IDLE unconditionally.
- Divide by zero: no special case. Raw result is quotient = all ones, remainder = dividend magnitude, then the sign fix-up is applied.
- Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, with no overflow flag.
- annul has priority over everything:
  - In any state, the next state is IDLE.
  - ready is not asserted and hi/lo are not updated.
  - A start in the same cycle as annul is dropped.
- start while in BUSY or DONE is ignored.
- hi/lo hold their last written values until the next DONE.

## Timing
- Reset (resetn low, asynchronous): state IDLE, counter 0, hi = 0, lo = 0, ready = 0, div_stall = 0.
- div_stall = (state == BUSY) | (state == IDLE & start & ~annul). It is combinational so the hazard logic stalls in the issue cycle. It is low in DONE so the instruction advances with the result.
- Latency: start at cycle T gives BUSY over T+1..T+WIDTH, DONE and ready at T+WIDTH+1. hi/lo become visible at the clock edge ending T+WIDTH+1, so they are valid from T+WIDTH+2. The HI/LO write path uses the registered hi/lo qualified by a registered copy of ready.
- div_stall is high for cycles T..T+WIDTH, which is WIDTH+1 cycles.
- Back-to-back: the earliest accepted next start is T+WIDTH+2.
- Reset asserted mid-operation: outputs go to reset values immediately. No ready pulse follows deassertion.

## Structure
- Shared package holds:
  - state encoding constants DIV_IDLE, DIV_BUSY, DIV_DONE
  - default width constant DIV_WIDTH = 32
  - counter width, derived as clog2(WIDTH)
- One sub-module, div_step: the combinational single restoring iteration (shift-in, compare, subtract, quotient bit). It is instanced once inside the BUSY datapath.
- Sign fix-up and the FSM stay in div_unit.

## Test plan
- DIVU 100 / 7, start at T: div_stall high T..T+32, ready at T+33, then lo = 14, hi = 2.
- DIV -7 / 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 7 / -2: lo = 0xFFFFFFFD, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. DIVU 0xFFFFFFFF / 1: lo = 0xFFFFFFFF, hi = 0.
- DIVU 5 / 0: lo = 0xFFFFFFFF, hi = 5. DIV -5 / 0: lo = 0x00000001, hi = 0xFFFFFFFB.
- Annul and restart:
  - Complete 100 / 7.
  - Start 9 / 3, then assert annul on BUSY cycle 10: IDLE next cycle, div_stall low, no ready, hi/lo stay 2/14.
  - Start 9 / 3 the following cycle: lo = 3, hi = 0.
- Start asserted during BUSY is ignored, with no change to the result.
- resetn pulsed low mid-BUSY: hi = lo = 0, div_stall = 0, and no ready pulse afterwards.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants and types for the iterative divider.
//   DIV_WIDTH  default operand width
//   DIV_CNT_W  step-counter width, clog2 of the operand width
//   div_state_e  FSM state encoding (DIV_IDLE, DIV_BUSY, DIV_DONE)
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage <-> divider signal bundle.
//   master: the pipeline side (issues start/operands/annul, consumes results)
//   slave : the divider
// Handshake: a divide is accepted in the cycle where start=1, annul=0 and
// the divider is idle (div_stall rises combinationally in that same cycle);
// completion is a single-cycle ready pulse, after which hi/lo hold the
// result until the next completion. annul kills any in-flight divide and
// drops a coincident start; no ready follows an annulled divide.
interface div_unit_if import div_unit_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             annul;
    logic             div_stall;
    logic             ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_div, a, b, annul,
        input  div_stall, ready, hi, lo
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output div_stall, ready, hi, lo
    );

endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division iteration.
//   r_i       partial remainder before the step (WIDTH+1 bits)
//   dvd_msb_i next dividend bit shifted into the remainder
//   dsr_i     divisor magnitude
//   r_o       partial remainder after the step
//   q_bit_o   quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH:0]   r_o,
    output logic             q_bit_o
);

    // One extra bit of headroom so the shifted value never truncates.
    logic [WIDTH+1:0] shifted;
    logic             ge;

    always_comb begin
        shifted = {r_i, dvd_msb_i};
        ge      = (shifted >= {2'b00, dsr_i});
        q_bit_o = ge;
        // The remainder stays below the divisor, so after a subtract the
        // result always fits back into WIDTH+1 bits.
        r_o     = ge ? (shifted[WIDTH:0] - {1'b0, dsr_i}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring 32-bit divider for MIPS DIV/DIVU.
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset
//   io        div_unit_if slave: start/signed_div/a/b/annul in,
//             div_stall/ready/hi (remainder)/lo (quotient) out
//   dbg_state current FSM state, for observation only
// Operands are converted to magnitudes on accept, divided unsigned over
// WIDTH cycles, and the signs are applied when the result is written.
module div_unit import div_unit_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  io,
    output div_state_e dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;   // dividend shifts out the top, quotient in the bottom
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH:0]   r_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   r_d;
    logic             q_bit_d;
    logic             a_neg;
    logic             b_neg;

    assign a_neg = io.signed_div & io.a[WIDTH-1];
    assign b_neg = io.signed_div & io.b[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i       (r_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dsr_i     (dsr_q),
        .r_o       (r_d),
        .q_bit_o   (q_bit_d)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            r_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (io.annul) begin
            // Flush wins over everything: drop the divide and any new start.
            state_q <= DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (io.start) begin
                        dvd_q   <= a_neg ? -io.a : io.a;
                        dsr_q   <= b_neg ? -io.b : io.b;
                        qneg_q  <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    r_q   <= r_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    lo_q    <= qneg_q ? -dvd_q : dvd_q;
                    hi_q    <= rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                    state_q <= DIV_IDLE;
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    // Stall covers the issue cycle too, so hazard logic reacts immediately;
    // it drops in DONE so the instruction advances alongside the result.
    assign io.div_stall = (state_q == DIV_BUSY) |
                          ((state_q == DIV_IDLE) & io.start & ~io.annul);
    assign io.ready     = (state_q == DIV_DONE) & ~io.annul;
    assign io.hi        = hi_q;
    assign io.lo        = lo_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;

    logic       clk;
    logic       resetn;
    div_state_e dbg_state;

    div_unit_if #(.WIDTH(W)) io ();

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .io        (io.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: {hi, lo} from plain arithmetic on the operands.
    function automatic logic [2*W-1:0] ref_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [W-1:0] lo, hi;
        if (b == 0) begin
            // All-ones quotient magnitude, remainder = dividend magnitude,
            // then signs restored: remainder always ends up equal to a.
            hi = a;
            lo = (sd && a[W-1]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[W-1:0];
            hi = r[W-1:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
        return {hi, lo};
    endfunction

    // ---------------- driver ----------------
    // Issues one divide, measures stall length and latency, then checks
    // hi/lo the cycle after ready. With noise set, random starts are
    // thrown at the divider while it is busy.
    task automatic do_div(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        int stall_cnt;
        int lat;
        bit got;
        logic [2*W-1:0] exp;
        @(negedge clk);
        io.start      = 1'b1;
        io.signed_div = sd;
        io.a          = a;
        io.b          = b;
        exp_q.push_back(ref_div(sd, a, b));
        #1;
        stall_cnt = io.div_stall ? 1 : 0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (noise && i >= 2 && i <= 30) begin
                io.start      = 1'($urandom_range(0, 1));
                io.signed_div = 1'($urandom_range(0, 1));
                io.a          = $urandom;
                io.b          = $urandom;
            end else begin
                io.start = 1'b0;
            end
            #1;
            stall_cnt += io.div_stall ? 1 : 0;
            if (io.ready) begin
                got = 1'b1;
                lat = i;
            end
        end
        io.start = 1'b0;
        check_eq("ready_latency", lat, W + 1);
        check_eq("stall_cycles", stall_cnt, W + 1);
        exp = exp_q.pop_front();
        @(negedge clk);
        #1;
        check_eq("lo", io.lo, exp[W-1:0]);
        check_eq("hi", io.hi, exp[2*W-1:W]);
        check_eq("ready_pulse_width", 32'(io.ready), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rdy_cnt;
        logic sd;
        logic [W-1:0] ra, rb;

        resetn        = 1'b0;
        io.start      = 1'b0;
        io.signed_div = 1'b0;
        io.a          = '0;
        io.b          = '0;
        io.annul      = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_hi", io.hi, 0);
        check_eq("rst_lo", io.lo, 0);
        check_eq("rst_ready", 32'(io.ready), 0);
        check_eq("rst_stall", 32'(io.div_stall), 0);
        check_eq("rst_state", 32'(dbg_state), 32'(DIV_IDLE));
        resetn = 1'b1;

        // Directed cases
        do_div(1'b0, 32'd100, 32'd7, 1'b0);
        do_div(1'b1, -32'sd7, 32'd2, 1'b0);
        do_div(1'b1, 32'd7, -32'sd2, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_div(1'b0, 32'd5, 32'd0, 1'b0);
        do_div(1'b1, -32'sd5, 32'd0, 1'b0);

        // Annul mid-divide after a completed 100/7
        do_div(1'b0, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        io.start = 1'b1; io.signed_div = 1'b0; io.a = 32'd9; io.b = 32'd3;
        @(negedge clk);
        io.start = 1'b0;
        repeat (9) @(negedge clk);
        io.annul = 1'b1;
        #1;
        check_eq("annul_busy_stall", 32'(io.div_stall), 1);
        check_eq("annul_ready", 32'(io.ready), 0);
        @(negedge clk);
        io.annul = 1'b0;
        #1;
        check_eq("annul_state", 32'(dbg_state), 32'(DIV_IDLE));
        check_eq("annul_stall", 32'(io.div_stall), 0);
        check_eq("annul_hi", io.hi, 32'd2);
        check_eq("annul_lo", io.lo, 32'd14);
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rdy_cnt += io.ready ? 1 : 0;
        end
        check_eq("annul_no_ready", rdy_cnt, 0);
        check_eq("annul_hold_lo", io.lo, 32'd14);
        do_div(1'b0, 32'd9, 32'd3, 1'b0);

        // Start coincident with annul is dropped
        @(negedge clk);
        io.start = 1'b1; io.annul = 1'b1; io.a = 32'd50; io.b = 32'd5;
        #1;
        check_eq("start_annul_stall", 32'(io.div_stall), 0);
        @(negedge clk);
        io.start = 1'b0; io.annul = 1'b0;
        #1;
        check_eq("start_annul_state", 32'(dbg_state), 32'(DIV_IDLE));

        // Starts while busy are ignored
        do_div(1'b0, 32'd1000, 32'd33, 1'b1);
        do_div(1'b1, -32'sd12345, 32'd77, 1'b1);

        // Reset in the middle of a divide
        @(negedge clk);
        io.start = 1'b1; io.signed_div = 1'b0; io.a = 32'd1000; io.b = 32'd3;
        @(negedge clk);
        io.start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("midrst_hi", io.hi, 0);
        check_eq("midrst_lo", io.lo, 0);
        check_eq("midrst_stall", 32'(io.div_stall), 0);
        check_eq("midrst_state", 32'(dbg_state), 32'(DIV_IDLE));
        @(negedge clk);
        resetn = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rdy_cnt += io.ready ? 1 : 0;
        end
        check_eq("midrst_no_ready", rdy_cnt, 0);

        // Randomized divides
        for (int n = 0; n < 24; n++) begin
            sd = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            do_div(sd, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
